// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM encoding and constants for the Sobel frame controller.
package sobel_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SRC = 3'd1,
      RUN      = 3'd2,
      FLUSH    = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Output rows/cols at top/left that are forced to zero (window not yet filled)
   localparam int BORDER = 2;

   // Detector result values
   localparam logic [7:0] EDGE_ON  = 8'd255;
   localparam logic [7:0] EDGE_OFF = 8'd0;

   // Width of the flush and pipeline-priming counters
   localparam int FLUSH_CW = 5;

endpackage

// File: rtl/sobel_pos_counter.sv
// sobel_pos_counter: column/row position counter with wrap and end-of-line /
// end-of-frame flags describing the current (not yet advanced) position.
module sobel_pos_counter #(
   parameter int MAX_COL = 640,
   parameter int MAX_ROW = 480,
   parameter int CW      = $clog2(MAX_COL),
   parameter int RW      = $clog2(MAX_ROW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_adv,
   output logic [CW-1:0] o_col,
   output logic [RW-1:0] o_row,
   output logic          o_eol,
   output logic          o_eof
);

   localparam logic [CW-1:0] LAST_COL = CW'(MAX_COL - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(MAX_ROW - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_eol;
   logic          w_eof;

   assign w_eol = (r_col == LAST_COL);
   assign w_eof = w_eol && (r_row == LAST_ROW);

   // Advance the position one pixel, wrapping the column at end of line and the row at end of frame
   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_adv) begin
         if (w_eol) begin
            r_col <= '0;
            r_row <= w_eof ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   assign o_col = r_col;
   assign o_row = r_row;
   assign o_eol = w_eol;
   assign o_eof = w_eof;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: pulls one frame from a valid/ready source, feeds the Sobel
// detector a gap-free line stream plus flush pixels, and retags detector results
// with SOF/EOL/EOF while blanking the border window.
// Define SOBEL_CTRL_STATS_EN to add the edge_count and underrun_count outputs.
module sobel_frame_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIPE_LAT   = 3,
   parameter int BORDER     = sobel_pkg::BORDER
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err_underrun,
`ifdef SOBEL_CTRL_STATS_EN
   output logic [19:0] edge_count,
   output logic [15:0] underrun_count,
`endif
   input  logic        src_valid,
   output logic        src_ready,
   input  logic [7:0]  src_pixel,
   output logic        det_valid_in,
   output logic [7:0]  det_pixel,
   input  logic        det_valid_out,
   input  logic [7:0]  det_edge,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eol,
   output logic        out_eof
);

   import sobel_pkg::*;

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [FLUSH_CW-1:0] LAT_CNT = FLUSH_CW'(PIPE_LAT);
   localparam logic [CW-1:0]       B_COL   = CW'(BORDER);
   localparam logic [RW-1:0]       B_ROW   = RW'(BORDER);

   state_t               r_state;
   state_t               w_next;
   logic [FLUSH_CW-1:0]  r_flush_cnt;
   logic [FLUSH_CW-1:0]  r_prime_cnt;
   logic                 r_frame_done;

   logic [CW-1:0]        w_in_col;
   logic [RW-1:0]        w_unused_in_row;
   logic                 w_unused_in_eol;
   logic                 w_in_eof;
   logic [CW-1:0]        w_out_col;
   logic [RW-1:0]        w_out_row;
   logic                 w_out_eol;
   logic                 w_out_eof;

   logic w_clr;
   logic w_accept;
   logic w_fill;
   logic w_in_beat;
   logic w_flush_go;
   logic w_flush_end;
   logic w_out_take;
   logic w_prime;
   logic w_fwd;
   logic w_border;

   // Source handshake: a pixel moves when src_valid and src_ready are both high in the
   // same cycle; src_ready depends only on state, never on src_valid.
   assign w_clr       = (r_state == IDLE) && start;
   assign w_accept    = src_valid && src_ready;
   // A mid-line starvation cycle is filled with a zero pixel so the detector line stays contiguous
   assign w_fill      = (r_state == RUN) && !src_valid && (w_in_col != '0);
   assign w_in_beat   = w_accept || w_fill;
   assign w_flush_go  = (r_state == FLUSH) && (r_flush_cnt < LAT_CNT);
   assign w_flush_end = (r_flush_cnt == LAT_CNT);

   // Result side: the first PIPE_LAT detector beats of a frame carry no valid pixel
   assign w_out_take  = det_valid_out && (r_state != IDLE) && !r_frame_done;
   assign w_prime     = (r_prime_cnt < LAT_CNT);
   assign w_fwd       = w_out_take && !w_prime;
   assign w_border    = (w_out_row < B_ROW) || (w_out_col < B_COL);

   sobel_pos_counter #(.MAX_COL(IMG_WIDTH), .MAX_ROW(IMG_HEIGHT), .CW(CW), .RW(RW)) u_in_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_clr),
      .i_adv (w_in_beat),
      .o_col (w_in_col),
      .o_row (w_unused_in_row),
      .o_eol (w_unused_in_eol),
      .o_eof (w_in_eof)
   );

   sobel_pos_counter #(.MAX_COL(IMG_WIDTH), .MAX_ROW(IMG_HEIGHT), .CW(CW), .RW(RW)) u_out_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_clr),
      .i_adv (w_fwd),
      .o_col (w_out_col),
      .o_row (w_out_row),
      .o_eol (w_out_eol),
      .o_eof (w_out_eof)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; start outside IDLE is ignored
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (start) w_next = WAIT_SRC;
         WAIT_SRC: if (w_accept) w_next = w_in_eof ? FLUSH : RUN;
         RUN:      if (w_in_beat && w_in_eof) w_next = FLUSH;
         FLUSH:    if (w_flush_end && r_frame_done) w_next = DONE;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // State-decoded control outputs
   always_comb begin
      busy      = 1'b0;
      src_ready = 1'b0;
      done      = 1'b0;
      case (r_state)
         WAIT_SRC, RUN: begin
            busy      = 1'b1;
            src_ready = 1'b1;
         end
         FLUSH:   busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Detector feed: accepted or filler pixels, then PIPE_LAT flush zeros
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         det_valid_in <= 1'b0;
         det_pixel    <= EDGE_OFF;
      end else if (w_in_beat) begin
         det_valid_in <= 1'b1;
         det_pixel    <= w_accept ? src_pixel : EDGE_OFF;
      end else begin
         det_valid_in <= w_flush_go;
         det_pixel    <= EDGE_OFF;
      end
   end

   // Flush counter and sticky underrun flag, both cleared by an accepted start
   always_ff @(posedge clk) begin
      if (!rst_n || w_clr) begin
         r_flush_cnt  <= '0;
         err_underrun <= 1'b0;
      end else begin
         if (w_flush_go) r_flush_cnt <= r_flush_cnt + FLUSH_CW'(1);
         if (w_fill)     err_underrun <= 1'b1;
      end
   end

   // Priming discard count and end-of-frame marker for the result side
   always_ff @(posedge clk) begin
      if (!rst_n || w_clr) begin
         r_prime_cnt  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_out_take && w_prime) r_prime_cnt  <= r_prime_cnt + FLUSH_CW'(1);
         if (w_fwd && w_out_eof)    r_frame_done <= 1'b1;
      end
   end

   // Registered, tagged and border-blanked result stream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= EDGE_OFF;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= w_fwd;
         out_data  <= (w_fwd && !w_border) ? det_edge : EDGE_OFF;
         out_sof   <= w_fwd && (w_out_col == '0) && (w_out_row == '0);
         out_eol   <= w_fwd && w_out_eol;
         out_eof   <= w_fwd && w_out_eof;
      end
   end

`ifdef SOBEL_CTRL_STATS_EN
   logic [19:0] r_edge_acc;

   // Per-frame edge tally published on entry to DONE; saturating underrun fill count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_edge_acc     <= '0;
         edge_count     <= '0;
         underrun_count <= '0;
      end else if (w_clr) begin
         r_edge_acc     <= '0;
         underrun_count <= '0;
      end else begin
         if (w_fwd && !w_border && (det_edge == EDGE_ON)) r_edge_acc <= r_edge_acc + 20'd1;
         if (w_fill && (underrun_count != 16'hFFFF))      underrun_count <= underrun_count + 16'd1;
         if ((r_state == FLUSH) && (w_next == DONE))      edge_count <= r_edge_acc;
      end
   end
`endif

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame-level sequencer in front of the Sobel edge detector. Accepts a software start command and pulls one IMG_WIDTH x IMG_HEIGHT frame from a valid/ready pixel source. Drives the detector's valid_in/pixel_data with a gap-free stream per line, then injects flush pixels so the pipeline drains. Retags detector results with SOF/EOL/EOF, blanks the invalid border window and reports completion and errors.

Parameters:
IMG_WIDTH, 640, pixels per line; must match the detector instance
IMG_HEIGHT, 480, lines per frame
PIPE_LAT, 3, detector latency in valid_in cycles (input accepted to result valid)
BORDER, 2, output rows/cols at top/left forced to 0 (window not yet filled)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last output pixel
err_underrun  out  1  sticky; source starved mid-line; cleared by start
src_valid  in  1  source pixel valid
src_ready  out  1  controller accepts pixel
src_pixel  in  8  source pixel
det_valid_in  out  1  to detector valid_in
det_pixel  out  8  to detector pixel_data
det_valid_out  in  1  from detector valid_out
det_edge  in  8  from detector edge_data
out_valid  out  1  tagged result valid
out_data  out  8  result (0 or 255; 0 in border)
out_sof  out  1  first pixel of frame, with out_valid
out_eol  out  1  last pixel of line, with out_valid
out_eof  out  1  last pixel of frame, with out_valid

Behaviour:
- Reset (rst_n low at posedge, synchronous): state IDLE; all outputs 0; counters 0; err_underrun 0. Reset mid-frame aborts; no done.
- FSM IDLE -> WAIT_SRC -> RUN -> FLUSH -> DONE -> IDLE.
- IDLE: busy=0, src_ready=0. start -> clear err_underrun, counters; WAIT_SRC next cycle. start while busy ignored.
- WAIT_SRC: src_ready=1; waits for the first src_valid. The first accepted pixel -> RUN.
- RUN: src_ready=1; each src_valid&src_ready cycle sets det_valid_in=1, det_pixel=src_pixel (registered, 1-cycle latency from accept). in_col/in_row advance; in_col wraps at IMG_WIDTH-1.
- RUN, src_valid low with in_col != 0: set err_underrun, insert zero pixel (det_valid_in=1, det_pixel=0) to keep the line gap-free. Gaps at line start (in_col==0) are legal, with no insertion.
- After pixel (IMG_WIDTH-1, IMG_HEIGHT-1) accepted -> FLUSH, src_ready=0.
- FLUSH: drives PIPE_LAT cycles of det_valid_in=1, det_pixel=0 (5-bit flush counter), then waits for the output count to reach frame size.
- Output side: counts det_valid_out beats with out_col/out_row. The first PIPE_LAT det_valid_out beats of a frame are discarded (pipeline priming).
- Output side, forwarded beats: out_valid=1, out_data=det_edge, except out_data=0 when out_row<BORDER or out_col<BORDER. Outputs are registered with 1-cycle latency from det_valid_out.
- Output side, beat exactly IMG_WIDTH*IMG_HEIGHT: out_eof=1 with out_eol=1. Beats beyond it are dropped.
- DONE: done=1 for one cycle, busy=0 next cycle.
- No downstream backpressure; the consumer must accept every out_valid beat.
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). All comparisons are unsigned.

Optional Feature:
SOBEL_CTRL_STATS_EN defined:
- Adds output edge_count (20 bits): the number of forwarded out_data==255 beats in the last completed frame. Updated at the done pulse; reset 0.
- Adds output underrun_count (16 bits), saturating; cleared by start.
Undefined: neither port nor counter exists.

Decomposition:
- Package sobel_pkg holds FSM state encoding (IDLE, WAIT_SRC, RUN, FLUSH, DONE), BORDER, and the edge/no-edge constants 8'd255/8'd0.
- One sub-module, sobel_pos_counter: col/row counter with wrap and eol/eof flags. Instantiated twice, for the input and output sides.

Test Plan:
1. IMG 8x6, continuous source after start: 48 det_valid_in beats plus 3 flush; 48 out_valid beats; sof on beat 0, eol every 8th, eof plus done once; err_underrun=0.
2. Uniform image (all 100): every out_data=0; rows 0-1 and cols 0-1 are 0 regardless of det_edge.
3. Source drops src_valid for 2 cycles at col 4: two zero pixels inserted; err_underrun=1 stays set until the next start.
4. start asserted during RUN: ignored, frame completes normally; a second start after done runs a fresh frame with sof again.
5. rst_n low mid-RUN for 1 cycle: next cycle busy=0 and all outputs 0; no done; a following start runs a clean frame.
6. SOBEL_CTRL_STATS_EN, a vertical step 0/255 at col 4: edge_count equals the count of non-border beats with det_edge=255, checked at done.
